// File: rtl/adder.sv
// rtl/adder.sv - WIDTH-bit two-level carry-lookahead adder with status flags and registered copy
module adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic [WIDTH-1:0] y_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             neg_q
);

   localparam int NG = WIDTH / 4;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;
   logic [NG-1:0]    grp_g;
   logic [NG-1:0]    grp_p;
   logic [NG:0]      grp_c;

   assign g = a & b;
   assign p = a ^ b;

   // Each 4-bit group derives its own G/P and internal carries from its group carry-in
   for (genvar j = 0; j < NG; j++) begin : g_cla
      localparam int B = 4 * j;

      assign grp_g[j] = g[B+3]
                      | (p[B+3] & g[B+2])
                      | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[j] = &p[B +: 4];

      assign c[B]   = grp_c[j];
      assign c[B+1] = g[B] | (p[B] & grp_c[j]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[j]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & grp_c[j]);
   end

   // Second-level lookahead: every group carry is a flat sum of products, no ripple between groups
   always_comb begin
      logic term;
      grp_c = '0;
      for (int j = 1; j <= NG; j++) begin
         for (int k = 0; k < j; k++) begin
            term = grp_g[k];
            for (int m = k + 1; m < j; m++) begin
               term = term & grp_p[m];
            end
            grp_c[j] = grp_c[j] | term;
         end
      end
   end

   assign y    = p ^ c;
   assign cout = grp_c[NG];
   assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
   assign zero = ~|y;
   assign neg  = y[WIDTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (en) begin
         y_q    <= y;
         cout_q <= cout;
         ovf_q  <= ovf;
         zero_q <= zero;
         neg_q  <= neg;
      end
   end

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - directed and model-checked vectors for adder, combinational and registered paths
module tb_adder;

   logic        clk;
   logic        reset;
   logic        en;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] y;
   logic        cout;
   logic        ovf;
   logic        zero;
   logic        neg;
   logic [31:0] y_q;
   logic        cout_q;
   logic        ovf_q;
   logic        zero_q;
   logic        neg_q;

   int tests_run;
   int tests_failed;

   adder #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .a      (a),
      .b      (b),
      .y      (y),
      .cout   (cout),
      .ovf    (ovf),
      .zero   (zero),
      .neg    (neg),
      .y_q    (y_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q),
      .zero_q (zero_q),
      .neg_q  (neg_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic comb_vec(input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] ey, input logic ec, input logic eo,
                           input logic ez, input logic en_);
      a = va;
      b = vb;
      #1;
      check($sformatf("y %h+%h", va, vb), {32'd0, y}, {32'd0, ey});
      check($sformatf("cout %h+%h", va, vb), {63'd0, cout}, {63'd0, ec});
      check($sformatf("ovf %h+%h", va, vb), {63'd0, ovf}, {63'd0, eo});
      check($sformatf("zero %h+%h", va, vb), {63'd0, zero}, {63'd0, ez});
      check($sformatf("neg %h+%h", va, vb), {63'd0, neg}, {63'd0, en_});
   endtask

   task automatic reg_chk(input string tag, input logic [31:0] ey, input logic ec,
                          input logic eo, input logic ez, input logic en_);
      check({tag, " y_q"}, {32'd0, y_q}, {32'd0, ey});
      check({tag, " cout_q"}, {63'd0, cout_q}, {63'd0, ec});
      check({tag, " ovf_q"}, {63'd0, ovf_q}, {63'd0, eo});
      check({tag, " zero_q"}, {63'd0, zero_q}, {63'd0, ez});
      check({tag, " neg_q"}, {63'd0, neg_q}, {63'd0, en_});
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [32:0] m_sum;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        m_ovf;

      tests_run    = 0;
      tests_failed = 0;
      reset = 1'b1;
      en    = 1'b0;
      a     = '0;
      b     = '0;

      step();
      reg_chk("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      comb_vec(32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1, 0);
      comb_vec(32'd10,       32'd15,       32'd25,       0, 0, 0, 0);
      comb_vec(32'd12345,    32'd67890,    32'h0001396B, 0, 0, 0, 0);
      comb_vec(32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0);
      comb_vec(32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1);
      comb_vec(32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1, 0, 0, 0);
      comb_vec(32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1, 0);
      comb_vec(32'h0000FFFF, 32'h00000001, 32'h00010000, 0, 0, 0, 0);
      comb_vec(32'h0FFFFFFF, 32'h00000001, 32'h10000000, 0, 0, 0, 0);
      comb_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 1);
      comb_vec(32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1, 1, 0, 0);
      comb_vec(32'h12345678, 32'h87654321, 32'h99999999, 0, 0, 0, 1);
      comb_vec(32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 0, 0, 0, 1);

      // Registered path: capture, hold with en low, recapture, reset overriding en
      reset = 1'b0;
      en    = 1'b1;
      a     = 32'd10;
      b     = 32'd15;
      step();
      reg_chk("cap25", 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);

      en = 1'b0;
      a  = 32'h7FFFFFFF;
      b  = 32'h00000001;
      step();
      reg_chk("hold", 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hold comb y", {32'd0, y}, {32'd0, 32'h80000000});

      en = 1'b1;
      step();
      reg_chk("cap80", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);

      a = 32'hFFFFFFFF;
      b = 32'h00000001;
      step();
      reg_chk("capwrap", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);

      a     = 32'h7FFFFFFF;
      b     = 32'h00000001;
      reset = 1'b1;
      step();
      reg_chk("rst_en", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst comb y", {32'd0, y}, {32'd0, 32'h80000000});
      check("rst comb ovf", {63'd0, ovf}, 64'd1);
      reset = 1'b0;
      en    = 1'b0;

      for (int i = 0; i < 500; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) ra = ra | 32'h80000000;
         if (i % 4 == 2) rb = rb & 32'h7FFFFFFF;
         a = ra;
         b = rb;
         #1;
         m_sum = {1'b0, ra} + {1'b0, rb};
         m_ovf = (ra[31] == rb[31]) && (m_sum[31] != ra[31]);
         check("rnd y", {32'd0, y}, {32'd0, m_sum[31:0]});
         check("rnd flags", {60'd0, cout, ovf, zero, neg},
               {60'd0, m_sum[32], m_ovf, (m_sum[31:0] == 32'd0), m_sum[31]});
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
